// File: rtl/alu_byte_sequencer_pkg.sv
// Shared definitions for the multi-byte ALU sequencer: opcodes, state
// encoding, strobe bundle and small opcode classification helpers.
package alu_seq_pkg;

  localparam int MAX_BYTES_DEF = 4;

  // Opcode encoding from the instruction decoder; 101-111 are illegal
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SBB = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;

  // State encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LDA   = 3'd1;
  localparam logic [2:0] ST_LDB   = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_SAVEC = 3'd4;
  localparam logic [2:0] ST_WRITE = 3'd5;
  localparam logic [2:0] ST_FIN   = 3'd6;
  localparam logic [2:0] ST_ERR   = 3'd7;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    LDA   = ST_LDA,
    LDB   = ST_LDB,
    EXEC  = ST_EXEC,
    SAVEC = ST_SAVEC,
    WRITE = ST_WRITE,
    FIN   = ST_FIN,
    ERR   = ST_ERR
  } state_e;

  // Every control output of the sequencer, kept together so it can be
  // registered as one word
  typedef struct packed {
    logic ready;
    logic busy;
    logic done;
    logic err;
    logic ia;
    logic ib;
    logic eo;
    logic alu_sub;
    logic iflags;
    logic itemp;
    logic cpt5;
    logic ires;
  } strobes_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_CMP);
  endfunction

  // SUB, SBB and CMP all run the ALU in subtract mode
  function automatic logic op_is_sub(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SBB) || (op == OP_CMP);
  endfunction

  // Ops that consume the carry-temp already at byte 0
  function automatic logic op_uses_cin(input logic [2:0] op);
    return (op == OP_ADC) || (op == OP_SBB);
  endfunction

endpackage

// File: rtl/alu_byte_sequencer_if.sv
// Decoder handshake plus datapath strobes of the byte sequencer.
interface alu_byte_sequencer_if #(
  parameter int IDX_W = 2
);
  // decoder side
  logic             start;
  logic [2:0]       opcode;
  logic [IDX_W-1:0] nbytes;
  logic             ready;
  logic             busy;
  logic             done;
  logic             err;
  // datapath side
  logic [IDX_W-1:0] byte_idx;
  logic             IA;
  logic             IB;
  logic             EO;
  logic             alu_sub;
  logic             IFLAGS;
  logic             ITEMP;
  logic             cpt5;
  logic             IRES;

  modport master (
    output start, opcode, nbytes,
    input  ready, busy, done, err,
    input  byte_idx, IA, IB, EO, alu_sub, IFLAGS, ITEMP, cpt5, IRES
  );

  modport slave (
    input  start, opcode, nbytes,
    output ready, busy, done, err,
    output byte_idx, IA, IB, EO, alu_sub, IFLAGS, ITEMP, cpt5, IRES
  );
endinterface

// File: rtl/alu_byte_sequencer_byte_counter.sv
// Byte index counter for multi-byte sequencers: clears on load while
// latching the last index, increments on request, flags the last byte.
module byte_counter #(
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [IDX_W-1:0] len_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [IDX_W-1:0] idx_nxt_o,
  output logic             last_o
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] len_q, len_d;

  // next index / latched length
  always_comb begin
    idx_d = idx_q;
    len_d = len_q;
    if (load_i) begin
      idx_d = '0;
      len_d = len_i;
    end else if (inc_i) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      len_q <= '0;
    end else begin
      idx_q <= idx_d;
      len_q <= len_d;
    end
  end

  assign idx_o     = idx_q;
  assign idx_nxt_o = idx_d;
  assign last_o    = (idx_q == len_q);

endmodule

// File: rtl/alu_byte_sequencer.sv
// Control FSM driving the byte-serial ALU datapath through ADD/ADC/SUB/SBB/CMP
// over 1..MAX_BYTES bytes. Byte k's carry-out is saved to the carry-temp and
// gated back in (cpt5) as byte k+1's carry-in.
module alu_byte_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MAX_BYTES = MAX_BYTES_DEF,
  parameter int IDX_W     = $clog2(MAX_BYTES)
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_byte_sequencer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  strobes_t         strb_q;

  logic             cnt_load, cnt_inc, cnt_last;
  logic [IDX_W-1:0] idx, idx_nxt, len_ld;

  // Lengths beyond the operand width are clamped so the index never wraps
  assign len_ld = (int'(bus.nbytes) >= MAX_BYTES) ? IDX_W'(MAX_BYTES - 1) : bus.nbytes;

  byte_counter #(.IDX_W(IDX_W)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .inc_i     (cnt_inc),
    .len_i     (len_ld),
    .idx_o     (idx),
    .idx_nxt_o (idx_nxt),
    .last_o    (cnt_last)
  );

  // Output word for a given state. Carry-in is gated only while the ALU
  // output is live; byte 0 takes it only for ADC/SBB.
  function automatic strobes_t decode(input state_e st, input logic [2:0] op,
                                      input logic [IDX_W-1:0] bidx);
    strobes_t s;
    s = '0;
    case (st)
      IDLE:    s.ready  = 1'b1;
      ERR:     s.err    = 1'b1;
      FIN:     s.done   = 1'b1;
      LDA:     begin s.busy = 1'b1; s.ia = 1'b1; end
      LDB:     begin s.busy = 1'b1; s.ib = 1'b1; end
      EXEC:    begin s.busy = 1'b1; s.eo = 1'b1; s.iflags = 1'b1; end
      SAVEC:   begin s.busy = 1'b1; s.itemp = 1'b1; end
      WRITE:   begin s.busy = 1'b1; s.eo = 1'b1; s.ires = 1'b1; end
      default: s = '0;
    endcase
    s.alu_sub = s.busy && op_is_sub(op);
    s.cpt5    = ((st == EXEC) || (st == WRITE)) && ((bidx != '0) || op_uses_cin(op));
    return s;
  endfunction

  // Next-state logic; the advance decision is shared by SAVEC (CMP) and WRITE
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (op_legal(bus.opcode)) begin
            op_d     = bus.opcode;
            cnt_load = 1'b1;
            state_d  = LDA;
          end else begin
            state_d  = ERR;
          end
        end
      end
      LDA:  state_d = LDB;
      LDB:  state_d = EXEC;
      EXEC: state_d = SAVEC;
      SAVEC: begin
        if (op_q != OP_CMP) begin
          state_d = WRITE;
        end else if (cnt_last) begin
          state_d = FIN;
        end else begin
          cnt_inc = 1'b1;
          state_d = LDA;
        end
      end
      WRITE: begin
        if (cnt_last) begin
          state_d = FIN;
        end else begin
          cnt_inc = 1'b1;
          state_d = LDA;
        end
      end
      FIN:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM registers; outputs are registered from the next state so they are
  // glitch-free and line up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      strb_q  <= decode(IDLE, OP_ADD, '0);
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      strb_q  <= decode(state_d, op_d, idx_nxt);
    end
  end

  assign bus.ready    = strb_q.ready;
  assign bus.busy     = strb_q.busy;
  assign bus.done     = strb_q.done;
  assign bus.err      = strb_q.err;
  assign bus.byte_idx = idx;
  assign bus.IA       = strb_q.ia;
  assign bus.IB       = strb_q.ib;
  assign bus.EO       = strb_q.eo;
  assign bus.alu_sub  = strb_q.alu_sub;
  assign bus.IFLAGS   = strb_q.iflags;
  assign bus.ITEMP    = strb_q.itemp;
  assign bus.cpt5     = strb_q.cpt5;
  assign bus.IRES     = strb_q.ires;

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Scoreboard bench: driver pushes expected outcomes computed with plain
// integer arithmetic; a negedge monitor pops on accept and checks strobes,
// latency, result bytes and final carry of a small byte-serial datapath.
module tb_alu_byte_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_byte_sequencer_if #(.IDX_W(2)) ifc();
  alu_byte_sequencer #(.MAX_BYTES(4), .IDX_W(2)) dut (.clk(clk), .rst(rst), .bus(ifc));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- byte-serial datapath harness ----------------
  logic [7:0] a_mem [4];
  logic [7:0] b_mem [4];
  logic [7:0] r_mem [4];
  logic [7:0] alu_a, alu_b, alu_r;
  logic       flag_c, ctemp;
  logic       preset_en  = 1'b0;
  logic       preset_val = 1'b0;

  always @(posedge clk) begin : hz
    logic [8:0] t;
    logic       cin;
    cin = ifc.cpt5 ? ctemp : 1'b0;
    if (ifc.alu_sub) t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, cin};
    else             t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, cin};
    if (preset_en) begin
      ctemp <= preset_val;
      for (int i = 0; i < 4; i++) r_mem[i] <= 8'h00;
    end
    if (ifc.IA)     alu_a <= a_mem[ifc.byte_idx];
    if (ifc.IB)     alu_b <= b_mem[ifc.byte_idx];
    if (ifc.IFLAGS) begin flag_c <= t[8]; alu_r <= t[7:0]; end
    if (ifc.ITEMP)  ctemp <= flag_c;
    if (ifc.IRES)   r_mem[ifc.byte_idx] <= alu_r;
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]  op;
    int          nb;
    logic [31:0] res;
    logic        c;
    int          lat;
    bit          is_err;
  } exp_t;

  exp_t exp_q[$];

  function automatic void ref_model(input logic [2:0] op, input int nb,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic tmp, output logic [31:0] res,
                                    output logic c);
    longint mask, am, bm, ci, v;
    mask = (longint'(1) << (8 * nb)) - 1;
    am   = longint'({32'd0, a}) & mask;
    bm   = longint'({32'd0, b}) & mask;
    ci   = ((op == OP_ADC) || (op == OP_SBB)) ? longint'(tmp) : 0;
    if ((op == OP_ADD) || (op == OP_ADC)) begin
      v   = am + bm + ci;
      c   = ((v >> (8 * nb)) & 1) != 0;
      res = 32'(v & mask);
    end else begin
      v   = am - bm - ci;
      c   = (v < 0);
      res = (op == OP_CMP) ? 32'd0 : 32'(v & mask);
    end
  endfunction

  // ---------------- monitor ----------------
  exp_t cur;
  bit   in_txn    = 0;
  bit   chk_ready = 0;
  int   cyc, ia_cnt, iflags_cnt, ires_cnt;
  int   sb_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_txn    = 0;
      chk_ready = 0;
    end else begin
      if (chk_ready) begin
        chk("ready_after_end", 32'(ifc.ready), 32'd1);
        chk_ready = 0;
      end
      if (in_txn) begin
        cyc++;
        chk("strobe_excl", 32'($countones({ifc.IA, ifc.IB, ifc.IFLAGS, ifc.ITEMP, ifc.IRES}) <= 1), 32'd1);
        if (cur.is_err)
          chk("err_no_strobe", 32'({ifc.IA, ifc.IB, ifc.EO, ifc.IFLAGS, ifc.ITEMP, ifc.cpt5, ifc.IRES, ifc.busy}), 32'd0);
        if (ifc.IA) begin
          chk("byte_idx", 32'(ifc.byte_idx), 32'(ia_cnt));
          ia_cnt++;
        end
        if (ifc.IFLAGS || ifc.IRES) begin
          chk("cpt5", 32'(ifc.cpt5), 32'((ia_cnt > 1) || (cur.op == OP_ADC) || (cur.op == OP_SBB)));
          chk("alu_sub", 32'(ifc.alu_sub), 32'((cur.op == OP_SUB) || (cur.op == OP_SBB) || (cur.op == OP_CMP)));
        end
        if (ifc.IFLAGS) iflags_cnt++;
        if (ifc.IRES)   ires_cnt++;
        if (ifc.done || ifc.err) begin
          chk("done_err_kind", 32'({ifc.done, ifc.err}), cur.is_err ? 32'd1 : 32'd2);
          chk("latency", 32'(cyc), 32'(cur.lat));
          if (!cur.is_err) begin
            chk("iflags_count", 32'(iflags_cnt), 32'(cur.nb));
            chk("ires_count", 32'(ires_cnt), (cur.op == OP_CMP) ? 32'd0 : 32'(cur.nb));
            chk("result", {r_mem[3], r_mem[2], r_mem[1], r_mem[0]}, cur.res);
            chk("carry", 32'(flag_c), 32'(cur.c));
          end
          in_txn    = 0;
          chk_ready = 1;
          sb_cnt++;
        end
      end else begin
        chk("idle_no_pulse", 32'({ifc.done, ifc.err, ifc.busy}), 32'd0);
      end
      if (ifc.ready && ifc.start) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_accept", 32'd0, 32'd1);
        end else begin
          cur        = exp_q.pop_front();
          in_txn     = 1;
          cyc        = 0;
          ia_cnt     = 0;
          iflags_cnt = 0;
          ires_cnt   = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input logic [2:0] op, input logic [1:0] n, input logic [31:0] a,
                        input logic [31:0] b, input logic tmp, input bit poke);
    exp_t e;
    int   prev;
    bit   ok;
    e.op     = op;
    e.nb     = int'(n) + 1;
    e.is_err = (op > OP_CMP);
    ref_model(op, e.nb, a, b, tmp, e.res, e.c);
    e.lat    = e.is_err ? 1 : (e.nb * ((op == OP_CMP) ? 4 : 5) + 1);
    for (int i = 0; i < 4; i++) begin
      a_mem[i] = a[8*i +: 8];
      b_mem[i] = b[8*i +: 8];
    end
    exp_q.push_back(e);
    prev       = sb_cnt;
    preset_en  = 1'b1;
    preset_val = tmp;
    ifc.start  = 1'b1;
    ifc.opcode = op;
    ifc.nbytes = n;
    @(posedge clk); #1;
    preset_en  = 1'b0;
    ifc.start  = 1'b0;
    ifc.opcode = 3'($urandom);
    ifc.nbytes = 2'($urandom);
    if (poke && !e.is_err) begin
      @(posedge clk); #1;
      ifc.start  = 1'b1;
      ifc.opcode = 3'($urandom);
      @(posedge clk); #1;
      ifc.start  = 1'b0;
    end
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sb_cnt != prev) begin ok = 1; break; end
    end
    chk("completes", 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  // Reset in byte-1 EXEC of a 4-byte ADD
  task automatic run_abort();
    exp_t e;
    int   prev;
    bit   found;
    e.op = OP_ADD; e.nb = 4; e.res = 32'd0; e.c = 1'b0; e.lat = 21; e.is_err = 0;
    exp_q.push_back(e);
    prev       = sb_cnt;
    ifc.start  = 1'b1;
    ifc.opcode = OP_ADD;
    ifc.nbytes = 2'd3;
    @(posedge clk); #1;
    ifc.start  = 1'b0;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ifc.IFLAGS && ifc.byte_idx == 2'd1) begin found = 1; break; end
    end
    chk("abort_reach_exec1", 32'(found), 32'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_strobes", 32'({ifc.IA, ifc.IB, ifc.EO, ifc.alu_sub, ifc.IFLAGS, ifc.ITEMP, ifc.cpt5, ifc.IRES}), 32'd0);
    chk("abort_ready", 32'(ifc.ready), 32'd1);
    chk("abort_idx", 32'(ifc.byte_idx), 32'd0);
    chk("abort_flags", 32'({ifc.busy, ifc.done, ifc.err}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_quiet", 32'({ifc.done, ifc.busy, ifc.IA, ifc.IRES}), 32'd0);
    end
    chk("abort_no_done", 32'(sb_cnt), 32'(prev));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] op;
    ifc.start  = 1'b0;
    ifc.opcode = 3'd0;
    ifc.nbytes = 2'd0;
    for (int i = 0; i < 4; i++) begin a_mem[i] = 8'h00; b_mem[i] = 8'h00; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ifc.ready), 32'd1);
    chk("rst_ctrl", 32'({ifc.busy, ifc.done, ifc.err, ifc.IA, ifc.IB, ifc.EO, ifc.alu_sub,
                         ifc.IFLAGS, ifc.ITEMP, ifc.cpt5, ifc.IRES}), 32'd0);
    chk("rst_idx", 32'(ifc.byte_idx), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    run_op(OP_ADD, 2'd0, $urandom, $urandom, 1'b1, 0);
    run_op(OP_ADD, 2'd3, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1);
    run_op(OP_CMP, 2'd1, $urandom, $urandom, 1'b0, 1);
    run_op(OP_ADC, 2'd0, 32'h01, 32'h01, 1'b1, 0);
    run_op(3'b110, 2'd2, $urandom, $urandom, 1'b0, 0);
    run_op(OP_SBB, 2'd3, 32'h0000_0000, 32'h0000_0001, 1'b1, 1);
    for (int t = 0; t < 40; t++) begin
      op = 3'($urandom_range(0, 7));
      run_op(op, 2'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
    end
    run_abort();
    run_op(OP_SUB, 2'd2, $urandom, $urandom, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
